// File: rtl/step_sequencer.sv
// Control-step sequencer: walks T0..T3 per instruction, stalls on memory, halts on request.
// Optional memory-wait watchdog enabled by defining STEP_SEQ_TIMEOUT_EN.
module step_sequencer (
  input  logic        clock,
  input  logic        clear,
  input  logic        run,
  input  logic        stop,
  input  logic        memReq,
  input  logic        memAck,
  input  logic        lastStep,
  output logic [1:0]  stepOut,
  output logic        stepValid,
  output logic        instrDone,
  output logic        runState,
  output logic [15:0] instrCount,
  output logic        timeoutFlag
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HALT = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  step_q, step_d;
  logic [15:0] count_q, count_d;
  logic        stop_pend_q, stop_pend_d;
  logic        step_valid_q, step_valid_d;
  logic        run_state_q, run_state_d;
  logic        instr_done_q, instr_done_d;

  logic        step_done_s;
  logic        last_s;
  logic        retire_s;
  logic        halt_req_s;
  logic        timeout_s;

  // Does the current step finish this cycle (same-cycle ack in RUN skips WAIT)
  always_comb begin
    step_done_s = 1'b0;
    case (state_q)
      ST_RUN:  step_done_s = ~memReq | memAck;
      ST_WAIT: step_done_s = memAck;
      default: step_done_s = 1'b0;
    endcase
  end

  assign last_s     = lastStep | (step_q == 2'd3);
  assign retire_s   = step_done_s & last_s;
  assign halt_req_s = stop_pend_q | stop;

`ifdef STEP_SEQ_TIMEOUT_EN
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       timeout_flag_q;

  // The 256th WAIT cycle is the one entered with the counter at 255
  assign timeout_s   = (state_q == ST_WAIT) & ~memAck & (wait_cnt_q == 8'hFF);
  assign wait_cnt_d  = (state_q == ST_WAIT) ? (wait_cnt_q + 8'd1) : 8'd0;
  assign timeoutFlag = timeout_flag_q;

  // Watchdog counter and sticky timeout flag
  always_ff @(posedge clock) begin
    if (clear) begin
      wait_cnt_q     <= 8'd0;
      timeout_flag_q <= 1'b0;
    end else begin
      wait_cnt_q     <= wait_cnt_d;
      timeout_flag_q <= timeout_flag_q | timeout_s;
    end
  end
`else
  assign timeout_s   = 1'b0;
  assign timeoutFlag = 1'b0;
`endif

  // Next-state and next-output computation
  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    count_d      = count_q;
    stop_pend_d  = stop_pend_q;
    instr_done_d = 1'b0;
    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (run) begin
          state_d = ST_RUN;
          step_d  = 2'd0;
        end else begin
          state_d = state_q;
        end
      end
      ST_RUN, ST_WAIT: begin
        if (stop) begin
          stop_pend_d = 1'b1;
        end else begin
          stop_pend_d = stop_pend_q;
        end
        if (timeout_s) begin
          state_d     = ST_HALT;
          step_d      = 2'd0;
          stop_pend_d = 1'b0;
        end else if (retire_s) begin
          step_d       = 2'd0;
          instr_done_d = 1'b1;
          count_d      = count_q + 16'd1;
          if (halt_req_s) begin
            state_d     = ST_HALT;
            stop_pend_d = 1'b0;
          end else begin
            state_d = ST_RUN;
          end
        end else if (step_done_s) begin
          state_d = ST_RUN;
          step_d  = step_q + 2'd1;
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        step_d      = 2'd0;
        stop_pend_d = 1'b0;
      end
    endcase
    step_valid_d = (state_d == ST_RUN);
    run_state_d  = (state_d == ST_RUN) | (state_d == ST_WAIT);
  end

  // Sequencer state and registered outputs
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q      <= ST_IDLE;
      step_q       <= 2'd0;
      count_q      <= 16'd0;
      stop_pend_q  <= 1'b0;
      step_valid_q <= 1'b0;
      run_state_q  <= 1'b0;
      instr_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      count_q      <= count_d;
      stop_pend_q  <= stop_pend_d;
      step_valid_q <= step_valid_d;
      run_state_q  <= run_state_d;
      instr_done_q <= instr_done_d;
    end
  end

  assign stepOut    = step_q;
  assign stepValid  = step_valid_q;
  assign runState   = run_state_q;
  assign instrDone  = instr_done_q;
  assign instrCount = count_q;

endmodule

// File: tb/tb_step_sequencer.sv
// Directed testbench for step_sequencer; ctl = {stepOut, stepValid, runState, instrDone}.
module tb_step_sequencer;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic        run = 1'b0;
  logic        stop = 1'b0;
  logic        memReq = 1'b0;
  logic        memAck = 1'b0;
  logic        lastStep = 1'b0;
  logic [1:0]  stepOut;
  logic        stepValid;
  logic        instrDone;
  logic        runState;
  logic [15:0] instrCount;
  logic        timeoutFlag;
  logic [4:0]  ctl;

  int pass_cnt = 0;
  int total_cnt = 0;

  step_sequencer dut (
    .clock(clock), .clear(clear), .run(run), .stop(stop), .memReq(memReq),
    .memAck(memAck), .lastStep(lastStep), .stepOut(stepOut), .stepValid(stepValid),
    .instrDone(instrDone), .runState(runState), .instrCount(instrCount),
    .timeoutFlag(timeoutFlag)
  );

  always #5 clock = ~clock;
  assign ctl = {stepOut, stepValid, runState, instrDone};

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    clear = 1'b1; run = 1'b1; stop = 1'b1;
    tick();
    total_cnt++; if (ctl !== 5'b00000) $display("FAIL reset ctl: got %b exp %b", ctl, 5'b00000); else pass_cnt++;
    total_cnt++; if (instrCount !== 16'd0) $display("FAIL reset count: got %h exp %h", instrCount, 16'd0); else pass_cnt++;
    total_cnt++; if (timeoutFlag !== 1'b0) $display("FAIL reset timeout: got %b exp %b", timeoutFlag, 1'b0); else pass_cnt++;
    clear = 1'b0; run = 1'b0;
    tick();
    total_cnt++; if (ctl !== 5'b00000) $display("FAIL idle_stop_ignored ctl: got %b exp %b", ctl, 5'b00000); else pass_cnt++;
    stop = 1'b0;
  endtask

  task automatic test_four_step();
    logic [4:0] exp_ctl [0:5];
    exp_ctl[0] = 5'b00110; exp_ctl[1] = 5'b01110; exp_ctl[2] = 5'b10110;
    exp_ctl[3] = 5'b11110; exp_ctl[4] = 5'b00111; exp_ctl[5] = 5'b01110;
    run = 1'b1;
    tick();
    run = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick();
      total_cnt++; if (ctl !== exp_ctl[i]) $display("FAIL four_step[%0d] ctl: got %b exp %b", i, ctl, exp_ctl[i]); else pass_cnt++;
    end
    total_cnt++; if (instrCount !== 16'd1) $display("FAIL four_step count: got %h exp %h", instrCount, 16'd1); else pass_cnt++;
  endtask

  task automatic test_last_step();
    lastStep = 1'b1;
    tick();
    lastStep = 1'b0;
    total_cnt++; if (ctl !== 5'b00111) $display("FAIL last_step ctl: got %b exp %b", ctl, 5'b00111); else pass_cnt++;
    total_cnt++; if (instrCount !== 16'd2) $display("FAIL last_step count: got %h exp %h", instrCount, 16'd2); else pass_cnt++;
    tick();
    total_cnt++; if (ctl !== 5'b01110) $display("FAIL last_step next ctl: got %b exp %b", ctl, 5'b01110); else pass_cnt++;
  endtask

  task automatic test_mem_wait();
    memReq = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total_cnt++; if (ctl !== 5'b01010) $display("FAIL mem_wait[%0d] ctl: got %b exp %b", i, ctl, 5'b01010); else pass_cnt++;
    end
    memAck = 1'b1;
    tick();
    total_cnt++; if (ctl !== 5'b10110) $display("FAIL mem_ack ctl: got %b exp %b", ctl, 5'b10110); else pass_cnt++;
    tick();
    total_cnt++; if (ctl !== 5'b11110) $display("FAIL same_cycle_ack ctl: got %b exp %b", ctl, 5'b11110); else pass_cnt++;
    memReq = 1'b0;
    tick();
    memAck = 1'b0;
    total_cnt++; if (ctl !== 5'b00111) $display("FAIL mem_retire ctl: got %b exp %b", ctl, 5'b00111); else pass_cnt++;
    total_cnt++; if (instrCount !== 16'd3) $display("FAIL mem_retire count: got %h exp %h", instrCount, 16'd3); else pass_cnt++;
  endtask

  task automatic test_stop();
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    total_cnt++; if (ctl !== 5'b10110) $display("FAIL stop_continue ctl: got %b exp %b", ctl, 5'b10110); else pass_cnt++;
    tick();
    tick();
    total_cnt++; if (ctl !== 5'b00001) $display("FAIL stop_halt ctl: got %b exp %b", ctl, 5'b00001); else pass_cnt++;
    total_cnt++; if (instrCount !== 16'd4) $display("FAIL stop_halt count: got %h exp %h", instrCount, 16'd4); else pass_cnt++;
    stop = 1'b1;
    tick();
    tick();
    stop = 1'b0;
    total_cnt++; if (ctl !== 5'b00000) $display("FAIL halt_hold ctl: got %b exp %b", ctl, 5'b00000); else pass_cnt++;
    total_cnt++; if (instrCount !== 16'd4) $display("FAIL halt_hold count: got %h exp %h", instrCount, 16'd4); else pass_cnt++;
    run = 1'b1;
    tick();
    run = 1'b0;
    total_cnt++; if (ctl !== 5'b00110) $display("FAIL halt_resume ctl: got %b exp %b", ctl, 5'b00110); else pass_cnt++;
    stop = 1'b1; lastStep = 1'b1;
    tick();
    stop = 1'b0; lastStep = 1'b0;
    total_cnt++; if (ctl !== 5'b00001) $display("FAIL stop_boundary ctl: got %b exp %b", ctl, 5'b00001); else pass_cnt++;
    total_cnt++; if (instrCount !== 16'd5) $display("FAIL stop_boundary count: got %h exp %h", instrCount, 16'd5); else pass_cnt++;
    run = 1'b1;
    tick();
    run = 1'b0; memReq = 1'b1;
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0; memAck = 1'b1; lastStep = 1'b1;
    total_cnt++; if (ctl !== 5'b00010) $display("FAIL stop_in_wait ctl: got %b exp %b", ctl, 5'b00010); else pass_cnt++;
    tick();
    memReq = 1'b0; memAck = 1'b0; lastStep = 1'b0;
    total_cnt++; if (ctl !== 5'b00001) $display("FAIL stop_wait_halt ctl: got %b exp %b", ctl, 5'b00001); else pass_cnt++;
    total_cnt++; if (instrCount !== 16'd6) $display("FAIL stop_wait_halt count: got %h exp %h", instrCount, 16'd6); else pass_cnt++;
  endtask

  task automatic test_wrap();
    clear = 1'b1;
    tick();
    clear = 1'b0; run = 1'b1;
    tick();
    run = 1'b0; lastStep = 1'b1;
    repeat (65535) tick();
    total_cnt++; if (instrCount !== 16'hFFFF) $display("FAIL wrap preload count: got %h exp %h", instrCount, 16'hFFFF); else pass_cnt++;
    tick();
    lastStep = 1'b0;
    total_cnt++; if (instrCount !== 16'h0000) $display("FAIL wrap count: got %h exp %h", instrCount, 16'h0000); else pass_cnt++;
    total_cnt++; if (ctl !== 5'b00111) $display("FAIL wrap ctl: got %b exp %b", ctl, 5'b00111); else pass_cnt++;
  endtask

  task automatic test_clear_in_wait();
    tick();
    tick();
    memReq = 1'b1;
    tick();
    total_cnt++; if (ctl !== 5'b10010) $display("FAIL pre_clear_wait ctl: got %b exp %b", ctl, 5'b10010); else pass_cnt++;
    clear = 1'b1; run = 1'b1; memAck = 1'b1;
    tick();
    clear = 1'b0; run = 1'b0; memReq = 1'b0; memAck = 1'b0;
    total_cnt++; if (ctl !== 5'b00000) $display("FAIL clear_wait ctl: got %b exp %b", ctl, 5'b00000); else pass_cnt++;
    total_cnt++; if (instrCount !== 16'd0) $display("FAIL clear_wait count: got %h exp %h", instrCount, 16'd0); else pass_cnt++;
    tick();
    total_cnt++; if (ctl !== 5'b00000) $display("FAIL idle_hold ctl: got %b exp %b", ctl, 5'b00000); else pass_cnt++;
  endtask

`ifdef STEP_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    run = 1'b1;
    tick();
    run = 1'b0; memReq = 1'b1;
    tick();
    repeat (255) tick();
    total_cnt++; if (ctl !== 5'b00010) $display("FAIL timeout_256th ctl: got %b exp %b", ctl, 5'b00010); else pass_cnt++;
    tick();
    total_cnt++; if (ctl !== 5'b00000) $display("FAIL timeout_halt ctl: got %b exp %b", ctl, 5'b00000); else pass_cnt++;
    total_cnt++; if (timeoutFlag !== 1'b1) $display("FAIL timeout_flag: got %b exp %b", timeoutFlag, 1'b1); else pass_cnt++;
    total_cnt++; if (instrCount !== 16'd0) $display("FAIL timeout count: got %h exp %h", instrCount, 16'd0); else pass_cnt++;
    memReq = 1'b0; run = 1'b1;
    tick();
    run = 1'b0; memReq = 1'b1;
    tick();
    repeat (255) tick();
    memAck = 1'b1;
    tick();
    memReq = 1'b0; memAck = 1'b0;
    total_cnt++; if (ctl !== 5'b01110) $display("FAIL ack_beats_timeout ctl: got %b exp %b", ctl, 5'b01110); else pass_cnt++;
    total_cnt++; if (timeoutFlag !== 1'b1) $display("FAIL timeout_sticky: got %b exp %b", timeoutFlag, 1'b1); else pass_cnt++;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    total_cnt++; if (timeoutFlag !== 1'b0) $display("FAIL timeout_clear: got %b exp %b", timeoutFlag, 1'b0); else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_four_step();
    test_last_step();
    test_mem_wait();
    test_stop();
    test_wrap();
    test_clear_in_wait();
`ifdef STEP_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
